seg_display_driver: RTL and testbench
=====================================

// Module: seg_display_driver
// PURPOSE
//  Board-side consumer of the pipeline top's pc_out / register_out debug outputs.
//  Time-multiplexes a 16-bit hex window of either value onto a 4-digit common-anode 7-seg display.
//  Debounces the board step button into a single-cycle step_pulse that clocks the pipeline by hand.
//  Runs on the free board clock, never on the stepped pipeline clock.
// PARAMETERS
//  REFRESH_DIV      1000  clock cycles each digit is driven (>=2)
//  BLANK_CYCLES     50    leading cycles of each digit slot with all anodes off (< REFRESH_DIV)
//  DEBOUNCE_CYCLES  20000 consecutive stable samples needed to accept a new button level
// PORTS
//  clock         in   1   board clock
//  reset         in   1   asynchronous, active-low reset
//  pc_in         in   32  pipeline pc_out
//  reg_in        in   32  pipeline register_out
//  view_sel      in   1   0 = show pc_in, 1 = show reg_in
//  half_sel      in   1   0 = bits [15:0], 1 = bits [31:16]
//  btn_step      in   1   raw, asynchronous step push-button, active-high
//  an            out  4   digit anodes, active-low; an[0] = rightmost digit (bits [3:0] of window)
//  seg           out  7   cathodes {g,f,e,d,c,b,a}, active-low
//  dp            out  1   decimal point, active-low; lit on digit 3 only when half_sel=1
//  step_pulse    out  1   one-cycle pulse per accepted button press
// BEHAVIOUR
//  Reset (reset=0, async): an=4'b1111, seg=7'h7F, dp=1, step_pulse=0, scan_cnt=0, digit_idx=0,
//   snapshot=16'h0000, debounce sync/stable/count = 0.
//  Scan: scan_cnt counts 0..REFRESH_DIV-1 and wraps. tick = (scan_cnt==REFRESH_DIV-1).
//   On tick, digit_idx <= digit_idx+1 (2-bit, wraps 3->0).
//  Snapshot: the 16-bit window (mux of view_sel/half_sel) is loaded into snapshot on tick when digit_idx==3,
//   so every full 4-digit frame shows one consistent value. Selector or input changes mid-frame take
//   effect at the next frame. Display reads 0000 until the first frame boundary after reset.
//  Outputs are registered, 1-cycle latency from scan_cnt/digit_idx:
//   - scan_cnt < BLANK_CYCLES: an=4'b1111, seg=7'h7F, dp=1 (anti-ghosting blank).
//   - otherwise: an = ~(4'b0001<<digit_idx); seg = font(snapshot nibble digit_idx); dp as above.
//  Font 0-F standard hex. b and d are lowercase. 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, A -> 7'h08, F -> 7'h0E.
//  Debounce:
//   - btn_step passes through a 2-FF synchronizer.
//   - When sync != stable, cnt increments; any sample equal to stable clears cnt.
//   - When cnt reaches DEBOUNCE_CYCLES-1 with sync != stable, stable <= sync and cnt <= 0.
//   - step_pulse <= stable rising edge, exactly 1 cycle high. A held button gives one pulse.
//   - A release followed by a press needs both edges to be accepted.
//   - Glitches shorter than DEBOUNCE_CYCLES never change stable.
//  Reset mid-press: all state clears. If the button is still held after reset, one pulse follows after
//   2 + DEBOUNCE_CYCLES cycles.
//  Simultaneous tick and frame boundary with an input change: the new window is captured (mux sampled that cycle).
// STRUCTURE
//  Shared package/header: SEG_FONT[0:15] constant table, SEG_BLANK=7'h7F, AN_OFF=4'hF.
//  Sub-module btn_debounce (sync + counter + edge detect, parameter DEBOUNCE_CYCLES; ports clock, reset,
//   btn, pulse). Scan counter, snapshot and font mux stay in the top.
// TESTING (REFRESH_DIV=4, BLANK_CYCLES=1, DEBOUNCE_CYCLES=3)
//  1. Reset, pc_in=32'h0040_1234, view_sel=0, half_sel=0 -> an stays 4'hF with seg=7'h7F during the first
//     frame. Next frame: digits 0..3 show 4,3,2,1 (seg 19,30,24,79 hex) with an E,D,B,7;
//     blank cycle at slot start.
//  2. Same pc_in, half_sel=1 -> frame shows 0,4,0,0, with dp=0 only on digit 3.
//  3. view_sel toggled to 1 (reg_in=32'h0000_ABCD) mid-frame -> current frame finishes on the old value;
//     next frame shows D,C,B,A.
//  4. btn_step high 2 cycles then low -> no step_pulse.
//     btn_step high 10 cycles -> exactly one step_pulse, 5 cycles after the rising edge.
//  5. Button held, reset pulsed low for 1 cycle mid-hold -> outputs return to reset values immediately;
//     one step_pulse follows after 2+DEBOUNCE_CYCLES cycles.
//  6. Run 100 frames with reg_in changing every cycle -> every frame's 4 nibbles equal one sampled reg_in
//     (scoreboard check).

Source files
------------

// File: rtl/seg_display_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver_pkg
// Purpose  : Shared constants for the 7-segment display driver. Contains the
//            active-low hex font {g,f,e,d,c,b,a} and the all-off codes for
//            the anodes and the segments.
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_driver_pkg;

    // Standard hex glyphs. The letters b and d are drawn in lower case so
    // that they cannot be confused with 8 and 0.
    localparam logic [6:0] SEG_FONT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage
`default_nettype wire

// File: rtl/seg_display_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver_if
// Purpose  : Board-side bundle of the display driver.
//            Board/debug side : pc_in, reg_in, view_sel, half_sel, btn_step
//            Display side     : an, seg, dp (all active-low), step_pulse
//            master = board/test side, slave = the driver itself.
// Revision : 1.0 - initial release
// ============================================================================
interface seg_display_driver_if;
    logic [31:0] pc_in;
    logic [31:0] reg_in;
    logic        view_sel;
    logic        half_sel;
    logic        btn_step;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        step_pulse;

    modport master (
        output pc_in, reg_in, view_sel, half_sel, btn_step,
        input  an, seg, dp, step_pulse
    );

    modport slave (
        input  pc_in, reg_in, view_sel, half_sel, btn_step,
        output an, seg, dp, step_pulse
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_driver_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronises a raw push-button, accepts a new level only after
//            DEBOUNCE_CYCLES consecutive agreeing samples, and emits a
//            one-cycle pulse on each accepted rising level.
// Ports    : clock  - free-running board clock
//            reset  - asynchronous, active-low
//            btn    - raw asynchronous button, active-high
//            pulse  - one-cycle pulse per accepted press
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_stable_q;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_pulse;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_q <= 1'b0;
            r_cnt      <= '0;
            r_pulse    <= 1'b0;
        end else begin
            r_sync1    <= btn;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
            r_pulse    <= r_stable & ~r_stable_q;
            // Any sample that agrees with the accepted level restarts the
            // run, so short glitches never accumulate across bounces.
            if (r_sync2 != r_stable) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_driver
// Purpose  : Time-multiplexes a 16-bit hex window of pc_in or reg_in onto a
//            4-digit common-anode display and turns the step button into a
//            debounced single-cycle step pulse. Runs on the board clock.
// Ports    : clock  - free-running board clock
//            reset  - asynchronous, active-low
//            bus    - slave side of seg_display_driver_if
//                     (pc_in, reg_in, view_sel, half_sel, btn_step in;
//                      an, seg, dp, step_pulse out)
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int REFRESH_DIV     = 1000,
    parameter int BLANK_CYCLES    = 50,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                 clock,
    input  logic                 reset,
    seg_display_driver_if.slave  bus
);

    localparam int c_SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(REFRESH_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_BLANK     = c_SCAN_W'(BLANK_CYCLES);

    logic [c_SCAN_W-1:0] r_scan_cnt;
    logic [1:0]          r_digit_idx;
    logic [15:0]         r_snapshot;
    logic                r_snap_half;
    logic [3:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic [31:0]         w_word;
    logic [15:0]         w_window;
    logic                w_tick;
    logic                w_blank;
    logic [3:0]          w_nibble;
    logic                w_step_pulse;

    always_comb begin
        w_word   = bus.view_sel ? bus.reg_in : bus.pc_in;
        w_window = bus.half_sel ? w_word[31:16] : w_word[15:0];
    end

    assign w_tick   = (r_scan_cnt == c_SCAN_LAST);
    assign w_blank  = (r_scan_cnt < c_BLANK);
    assign w_nibble = r_snapshot[{r_digit_idx, 2'b00} +: 4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= 2'd0;
            r_snapshot  <= 16'h0000;
            r_snap_half <= 1'b0;
            r_an        <= AN_OFF;
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
        end else begin
            r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
            if (w_tick) begin
                r_digit_idx <= r_digit_idx + 2'd1;
            end
            // Capture once per frame so all four digits come from one value.
            // The half selection is captured with it so the dp marker always
            // describes the digits actually on display.
            if (w_tick && (r_digit_idx == 2'd3)) begin
                r_snapshot  <= w_window;
                r_snap_half <= bus.half_sel;
            end
            if (w_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(4'b0001 << r_digit_idx);
                r_seg <= SEG_FONT[w_nibble];
                r_dp  <= ~((r_digit_idx == 2'd3) && r_snap_half);
            end
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock (clock),
        .reset (reset),
        .btn   (bus.btn_step),
        .pulse (w_step_pulse)
    );

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.step_pulse = w_step_pulse;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_driver
// Purpose  : Self-checking bench for seg_display_driver. A cycle-indexed
//            model predicts every output; directed literals pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_driver;

    localparam int R  = 4;
    localparam int B  = 1;
    localparam int D  = 3;
    localparam int FR = 4 * R;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    seg_display_driver_if bus ();

    seg_display_driver #(
        .REFRESH_DIV     (R),
        .BLANK_CYCLES    (B),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [6:0] tb_font [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // n_edges = number of clock edges since reset release; the outputs seen
    // after edge k are a pure function of k and the value frozen at the last
    // frame boundary (edges with k mod 16 == 15).
    int          n_edges;
    logic [15:0] m_snap, m_snap_old;
    logic        m_half;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_pulse;
    logic        m_b1, m_b2, m_stab, m_rise;
    int          m_run;

    function automatic logic [15:0] window(input logic v, input logic h,
                                           input logic [31:0] p, input logic [31:0] r);
        logic [31:0] w;
        w = v ? r : p;
        return h ? w[31:16] : w[15:0];
    endfunction

    function automatic bit is_blank(input int k);
        return (k % R) < B;
    endfunction

    function automatic int digit_of(input int k);
        return (k / R) % 4;
    endfunction

    function automatic logic [3:0] an_for(input int k);
        if (is_blank(k)) return 4'hF;
        return 4'hF ^ (4'b0001 << digit_of(k));
    endfunction

    function automatic logic [6:0] seg_for(input int k, input logic [15:0] s);
        if (is_blank(k)) return 7'h7F;
        return tb_font[int'((s >> (4 * digit_of(k))) & 16'hF)];
    endfunction

    function automatic logic dp_for(input int k, input logic h);
        if (is_blank(k)) return 1'b1;
        return !(digit_of(k) == 3 && h);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_edges    <= 0;
            m_snap     <= 16'h0;
            m_snap_old <= 16'h0;
            m_half     <= 1'b0;
            exp_an     <= 4'hF;
            exp_seg    <= 7'h7F;
            exp_dp     <= 1'b1;
            exp_pulse  <= 1'b0;
            m_b1       <= 1'b0;
            m_b2       <= 1'b0;
            m_stab     <= 1'b0;
            m_run      <= 0;
            m_rise     <= 1'b0;
        end else begin
            exp_an  <= an_for(n_edges);
            exp_seg <= seg_for(n_edges, m_snap);
            exp_dp  <= dp_for(n_edges, m_half);
            if (n_edges % FR == FR - 1) begin
                m_snap     <= window(bus.view_sel, bus.half_sel, bus.pc_in, bus.reg_in);
                m_snap_old <= m_snap;
                m_half     <= bus.half_sel;
            end
            n_edges <= n_edges + 1;
            // Button seen two cycles late; a new level needs D consecutive
            // disagreeing samples; a rising acceptance pulses one cycle later.
            m_b1 <= bus.btn_step;
            m_b2 <= m_b1;
            if (m_b2 != m_stab) begin
                if (m_run == D - 1) begin
                    m_stab <= m_b2;
                    m_run  <= 0;
                    m_rise <= m_b2;
                end else begin
                    m_run  <= m_run + 1;
                    m_rise <= 1'b0;
                end
            end else begin
                m_run  <= 0;
                m_rise <= 1'b0;
            end
            exp_pulse <= m_rise;
        end
    end

    // ---------------- compare + frame scoreboard ----------------
    bit         cmp_en = 1'b0;
    bit         sb_en  = 1'b0;
    int         pulse_cnt = 0;
    int         sb_frames = 0;
    logic [3:0] fr_nib [4];

    function automatic logic [4:0] decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) begin
            if (tb_font[i] == s) return 5'(i);
        end
        return 5'h10;
    endfunction

    initial begin
        forever begin
            @(negedge clock);
            if (cmp_en) begin
                chk("an",    32'(bus.an),         32'(exp_an));
                chk("seg",   32'(bus.seg),        32'(exp_seg));
                chk("dp",    32'(bus.dp),         32'(exp_dp));
                chk("pulse", 32'(bus.step_pulse), 32'(exp_pulse));
                if (bus.step_pulse) pulse_cnt++;
                if (sb_en && bus.an != 4'hF) begin
                    logic [4:0] nib;
                    int dg;
                    nib = decode(bus.seg);
                    case (bus.an)
                        4'hE:    dg = 0;
                        4'hD:    dg = 1;
                        4'hB:    dg = 2;
                        default: dg = 3;
                    endcase
                    if ((n_edges - 1) % FR == FR - 1) begin
                        chk("frame", {16'h0, nib[3:0], fr_nib[2], fr_nib[1], fr_nib[0]},
                            {16'h0, m_snap_old});
                        sb_frames++;
                    end else begin
                        fr_nib[dg] = nib[3:0];
                    end
                end
            end
        end
    end

    task automatic wait_n(input int t);
        int g;
        g = 0;
        while (n_edges < t && g < 5000) begin
            @(negedge clock);
            g++;
        end
        chk("wait_n", 32'(n_edges), 32'(t));
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp);
        chk({name, "_an"},  32'(bus.an),  32'(an));
        chk({name, "_seg"}, 32'(bus.seg), 32'(seg));
        chk({name, "_dp"},  32'(bus.dp),  32'(dp));
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int k0, p0, t0;
        bus.pc_in    = 32'h0040_1234;
        bus.reg_in   = 32'h0000_0000;
        bus.view_sel = 1'b0;
        bus.half_sel = 1'b0;
        bus.btn_step = 1'b0;
        reset        = 1'b0;
        repeat (3) @(negedge clock);
        cmp_en = 1'b1;
        lit("reset", 4'hF, 7'h7F, 1'b1);
        chk("reset_pulse", 32'(bus.step_pulse), 32'h0);
        reset = 1'b1;

        // 1: first frame shows the cleared snapshot, then 1234
        wait_n(2);  lit("f0_d0", 4'hE, 7'h40, 1'b1);
        wait_n(17); lit("f1_blank", 4'hF, 7'h7F, 1'b1);
        wait_n(18); lit("f1_d0", 4'hE, 7'h19, 1'b1);
        wait_n(22); lit("f1_d1", 4'hD, 7'h30, 1'b1);
        wait_n(26); lit("f1_d2", 4'hB, 7'h24, 1'b1);
        wait_n(30); lit("f1_d3", 4'h7, 7'h79, 1'b1);

        // 2: upper half 0040, dp on digit 3 only
        bus.half_sel = 1'b1;
        wait_n(34); lit("f2_d0", 4'hE, 7'h40, 1'b1);
        wait_n(38); lit("f2_d1", 4'hD, 7'h19, 1'b1);
        wait_n(42); lit("f2_d2", 4'hB, 7'h40, 1'b1);
        wait_n(46); lit("f2_d3", 4'h7, 7'h40, 1'b0);

        // 3: switch to reg_in mid-frame; old value persists to frame end
        wait_n(52);
        bus.reg_in   = 32'h0000_ABCD;
        bus.view_sel = 1'b1;
        bus.half_sel = 1'b0;
        wait_n(54); lit("f3_d1", 4'hD, 7'h19, 1'b1);
        wait_n(62); lit("f3_d3", 4'h7, 7'h40, 1'b0);
        wait_n(66); lit("f4_d0", 4'hE, 7'h21, 1'b1);
        wait_n(70); lit("f4_d1", 4'hD, 7'h46, 1'b1);
        wait_n(74); lit("f4_d2", 4'hB, 7'h03, 1'b1);
        wait_n(78); lit("f4_d3", 4'h7, 7'h08, 1'b1);

        // 4: 2-cycle glitch rejected; 10-cycle press gives one pulse at +5
        bus.btn_step = 1'b1;
        repeat (2) @(negedge clock);
        bus.btn_step = 1'b0;
        repeat (12) @(negedge clock);
        chk("glitch_pulses", 32'(pulse_cnt), 32'h0);
        k0 = n_edges;
        bus.btn_step = 1'b1;
        wait_n(k0 + 5); chk("press_pre",  32'(bus.step_pulse), 32'h0);
        wait_n(k0 + 6); chk("press_hit",  32'(bus.step_pulse), 32'h1);
        wait_n(k0 + 7); chk("press_post", 32'(bus.step_pulse), 32'h0);
        wait_n(k0 + 10);
        bus.btn_step = 1'b0;
        repeat (12) @(negedge clock);
        chk("press_pulses", 32'(pulse_cnt), 32'h1);

        // 5: reset pulse while the button is held
        p0 = pulse_cnt;
        bus.btn_step = 1'b1;
        repeat (8) @(negedge clock);
        #2 reset = 1'b0;
        #1 lit("midrst", 4'hF, 7'h7F, 1'b1);
        chk("midrst_pulse", 32'(bus.step_pulse), 32'h0);
        @(negedge clock);
        #2 reset = 1'b1;
        wait_n(5); chk("rst_press_pre", 32'(bus.step_pulse), 32'h0);
        wait_n(6); chk("rst_press_hit", 32'(bus.step_pulse), 32'h1);
        wait_n(7); chk("rst_press_post", 32'(bus.step_pulse), 32'h0);
        repeat (10) @(negedge clock);
        chk("rst_press_pulses", 32'(pulse_cnt), 32'(p0 + 2));
        bus.btn_step = 1'b0;
        repeat (10) @(negedge clock);

        // 6: reg_in changes every cycle for 100 frames
        bus.view_sel = 1'b1;
        bus.half_sel = 1'b0;
        t0 = (n_edges / FR + 1) * FR + 1;
        wait_n(t0);
        sb_en = 1'b1;
        for (int i = 0; i < 100 * FR; i++) begin
            bus.reg_in = (32'h1357_9BDF * 32'(i + 1)) ^ (32'(i) << 7);
            @(negedge clock);
        end
        #1 sb_en = 1'b0;
        chk("sb_frames", 32'(sb_frames), 32'd100);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
